addr_seq: RTL and testbench

- Address sequencer that drives the address ALU (cmd = INC) to emit a run of consecutive addresses for block memory operations such as copy, fill and string scan.
- Loaded with a start address and a count; emits one address per accepted valid/ready handshake.
- Signals completion with a one-cycle done pulse.
- Sits between the instruction control FSM (start/abort) and the memory interface (out_valid/out_ready), and owns one addr_alu instance.

---
 rtl/addr_seq.sv | 173 +++++++++++++++++
 tb/tb_addr_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq.sv
// Address sequencer: emits start_addr .. start_addr+count-1 over a valid/ready port, then pulses done.
// Optional build macro ADDR_SEQ_WRAP_ERR_EN: a run that would wrap past all-ones stops with a wrap_err pulse.

package addr_seq_pkg;
    localparam int unsigned ADDR_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_INC  = 2'd1,
        ALU_DEC  = 2'd2,
        ALU_ADD  = 2'd3
    } alu_cmd_t;
endpackage

// Address ALU: modular address arithmetic, zflag set when the result is zero.
module addr_alu
    import addr_seq_pkg::*;
(
    input  addr_t    x,
    input  addr_t    y,
    input  alu_cmd_t cmd,
    output addr_t    z,
    output logic     zflag
);

    always_comb begin
        z = x;
        case (cmd)
            ALU_PASS: z = x;
            ALU_INC:  z = x + addr_t'(1);
            ALU_DEC:  z = x - addr_t'(1);
            ALU_ADD:  z = x + y;
            default:  z = x;
        endcase
        zflag = (z == addr_t'(0));
    end

endmodule

module addr_seq
    import addr_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  addr_t            start_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output addr_t            out_addr,
    output logic             busy,
    output logic             done
`ifdef ADDR_SEQ_WRAP_ERR_EN
    ,
    output logic             wrap_err
`endif
);

`ifdef ADDR_SEQ_WRAP_ERR_EN
    localparam bit WRAP_STOP = 1'b1;
`else
    localparam bit WRAP_STOP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    addr_t            addr_q;
    addr_t            addr_nxt;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_nxt;
    addr_t            alu_z;
    logic             alu_zflag;
    logic             handshake;
    logic             wrap_hit;
    logic             wrap_nxt;

    addr_alu u_alu (
        .x     (addr_q),
        .y     (addr_t'(0)),
        .cmd   (ALU_INC),
        .z     (alu_z),
        .zflag (alu_zflag)
    );

    assign out_addr = addr_q;

    // Next state; abort outranks any handshake or completion in the same cycle.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        rem_nxt   = rem_q;
        wrap_nxt  = 1'b0;
        handshake = out_valid && out_ready;
        wrap_hit  = WRAP_STOP && alu_zflag;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (count != '0) begin
                        state_nxt = S_EMIT;
                        addr_nxt  = start_addr;
                        rem_nxt   = count;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_EMIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (handshake) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                    end else if (wrap_hit) begin
                        // All-ones address was just transferred; refuse to wrap.
                        state_nxt = S_IDLE;
                        wrap_nxt  = 1'b1;
                    end else begin
                        addr_nxt = alu_z;
                        rem_nxt  = rem_q - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr_q    <= addr_t'(0);
            rem_q     <= CNT_W'(0);
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            rem_q     <= rem_nxt;
            out_valid <= (state_nxt == S_EMIT);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
        end
    end

`ifdef ADDR_SEQ_WRAP_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_err <= 1'b0;
        end else begin
            wrap_err <= wrap_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_addr_seq.sv
// Testbench for addr_seq: randomized and directed runs, expected transfers queued by a transaction model
// and popped by an independent monitor.
module tb_addr_seq;
    import addr_seq_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int EV_ADDR = 0;
    localparam int EV_DONE = 1;
    localparam int EV_WRAP = 2;
    localparam int CYC_LIMIT = 400;

    typedef struct {
        int kind;
        int addr;
    } ev_t;

    logic             clk;
    logic             reset_n;
    logic             start;
    addr_t            start_addr;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    addr_t            out_addr;
    logic             busy;
    logic             done;
`ifdef ADDR_SEQ_WRAP_ERR_EN
    logic             wrap_err;
`endif

    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    addr_seq #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done)
`ifdef ADDR_SEQ_WRAP_ERR_EN
        ,
        .wrap_err   (wrap_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int kind, input int addr);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int kind, input int addr);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: actual kind=%0d addr=%0h required=none (t=%0t)", kind, addr, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_ADDR && e.kind == EV_ADDR) check("event_addr", addr, e.addr);
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled its inputs for that cycle.
    initial begin
        bit    prev_stall;
        addr_t prev_addr;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", int'(out_valid), 1);
                    check("stall_hold_addr", int'(out_addr), int'(prev_addr));
                end
                prev_stall = out_valid && !out_ready;
                prev_addr  = out_addr;
                if (out_valid && out_ready) observe(EV_ADDR, int'(out_addr));
                if (done) observe(EV_DONE, 0);
`ifdef ADDR_SEQ_WRAP_ERR_EN
                if (wrap_err) observe(EV_WRAP, 0);
`endif
            end
        end
    end

    // One run from IDLE back to IDLE. abort_at=k>0 aborts on the k-th accept.
    task automatic run_seq(input addr_t a, input int cnt, input int abort_at,
                           input bit use_pat, input logic [31:0] pat, input bit junk);
        int n_eff;
        int n_stop;
        int hs;
        int cyc;
        bit wrap;
        bit aborted;
        n_eff = cnt;
        wrap  = 1'b0;
`ifdef ADDR_SEQ_WRAP_ERR_EN
        if (cnt > 65536 - int'(a)) begin
            n_eff = 65536 - int'(a);
            wrap  = 1'b1;
        end
`endif
        aborted = (abort_at > 0) && (abort_at <= n_eff);
        n_stop  = aborted ? abort_at : n_eff;
        for (int i = 0; i < n_stop; i++) push_ev(EV_ADDR, (int'(a) + i) % 65536);
        if (!aborted) push_ev(wrap ? EV_WRAP : EV_DONE, 0);

        start      = 1'b1;
        start_addr = a;
        count      = CNT_W'(cnt);
        @(negedge clk);
        start = 1'b0;
        hs    = 0;
        cyc   = 0;
        while (hs < n_stop && cyc < CYC_LIMIT) begin
            check("valid_in_run", int'(out_valid), 1);
            check("busy_in_run", int'(busy), 1);
            out_ready = use_pat ? pat[cyc % 32] : ($urandom_range(0, 3) != 0);
            abort     = out_ready && (hs + 1 == abort_at);
            start     = junk && ($urandom_range(0, 1) == 1);
            if (start) begin
                start_addr = addr_t'($urandom);
                count      = CNT_W'($urandom);
            end
            if (out_ready) hs++;
            @(negedge clk);
            cyc++;
        end
        if (hs < n_stop) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: actual accepts=%0d required=%0d", hs, n_stop);
        end
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = ($urandom_range(0, 1) == 1);
        if (aborted || wrap) begin
            check("end_busy", int'(busy), 0);
            check("end_done", int'(done), 0);
        end else begin
            check("done_pulse", int'(done), 1);
            check("done_busy", int'(busy), 1);
        end
        check("end_valid", int'(out_valid), 0);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(out_valid), 0);
        check("idle_done", int'(done), 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_addr", int'(out_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_seq(16'h0010, 4, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_seq(16'h0100, 3, 0, 1'b1, 32'h0000_0034, 1'b0);
        run_seq(16'h1234, 0, 0, 1'b0, 32'h0, 1'b0);
        run_seq(16'h0400, 6, 0, 1'b0, 32'h0, 1'b1);
        run_seq(16'h0200, 10, 2, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_seq(16'h0500, 2, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_seq(16'h0600, 3, 3, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_seq(16'hFFFE, 4, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_seq(16'hFFFF, 1, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);

        // abort together with start in IDLE: nothing happens.
        start      = 1'b1;
        abort      = 1'b1;
        start_addr = 16'h0777;
        count      = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_valid", int'(out_valid), 0);
        @(negedge clk);

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            addr_t a;
            int    cnt;
            int    ab;
            a   = ($urandom_range(0, 3) == 0) ? addr_t'(16'hFFF0 + $urandom_range(0, 15))
                                              : addr_t'($urandom);
            cnt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, (cnt > 0) ? cnt : 1)) : 0;
            run_seq(a, cnt, ab, 1'b0, 32'h0, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 3; i++) push_ev(EV_ADDR, 16'h0300 + i);
        start      = 1'b1;
        start_addr = 16'h0300;
        count      = CNT_W'(10);
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_addr", int'(out_addr), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_done", int'(done), 0);
        run_seq(16'h0800, 2, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
